// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding, widths and operand-signedness helpers.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CALC   = 2'b01,
        S_FINISH = 2'b10,
        S_DONE   = 2'b11
    } state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        logic r;
        case (f3)
            F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        logic r;
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand latches, shared shift-add / restoring-divide accumulators and
// final sign fix-up; the result register only changes on completion.
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            finish,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            special,
    output logic [XLEN-1:0] result
);

    logic [2:0]      f3_r;
    logic [XLEN-1:0] opnd_r;
    logic [XLEN:0]   acc_hi_r;
    logic [XLEN-1:0] acc_lo_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic [XLEN-1:0] result_r;

    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            ovf_s;
    logic            special_s;
    logic [XLEN-1:0] special_res_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   shift_s;
    logic [XLEN+1:0] diff_s;
    logic [XLEN:0]   next_hi_s;
    logic [XLEN-1:0] next_lo_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quo_s;
    logic [XLEN-1:0] rem_s;
    logic [XLEN-1:0] fin_res_s;

    // Operand magnitudes, sign flags and special-case detection at start.
    always_comb begin
        a_neg_s = rs1_signed(funct3) & rs1_val[XLEN-1];
        b_neg_s = rs2_signed(funct3) & rs2_val[XLEN-1];
        a_mag_s = a_neg_s ? (~rs1_val + 32'd1) : rs1_val;
        b_mag_s = b_neg_s ? (~rs2_val + 32'd1) : rs2_val;
        ovf_s   = rs1_signed(funct3) && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
        special_s = is_div(funct3) && ((rs2_val == 32'd0) || ovf_s);
        case (funct3)
            F3_DIV:  special_res_s = ovf_s ? 32'h8000_0000 : 32'hFFFF_FFFF;
            F3_DIVU: special_res_s = 32'hFFFF_FFFF;
            F3_REM:  special_res_s = ovf_s ? 32'd0 : rs1_val;
            F3_REMU: special_res_s = rs1_val;
            default: special_res_s = 32'd0;
        endcase
    end

    // One radix-2 iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        sum_s   = {1'b0, acc_hi_r[XLEN-1:0]} + (acc_lo_r[0] ? {1'b0, opnd_r} : 33'd0);
        shift_s = {acc_hi_r[XLEN-1:0], acc_lo_r[XLEN-1]};
        diff_s  = {1'b0, shift_s} - {2'b00, opnd_r};
        if (is_div(f3_r)) begin
            if (diff_s[XLEN+1]) begin
                next_hi_s = shift_s;
                next_lo_s = {acc_lo_r[XLEN-2:0], 1'b0};
            end else begin
                next_hi_s = diff_s[XLEN:0];
                next_lo_s = {acc_lo_r[XLEN-2:0], 1'b1};
            end
        end else begin
            next_hi_s = {1'b0, sum_s[XLEN:1]};
            next_lo_s = {sum_s[0], acc_lo_r[XLEN-1:1]};
        end
    end

    // Sign correction and result-field selection once iterations finish.
    always_comb begin
        prod_s = {acc_hi_r[XLEN-1:0], acc_lo_r};
        if (neg_q_r) begin
            prod_s = ~prod_s + 64'd1;
        end else begin
            prod_s = prod_s;
        end
        quo_s = neg_q_r ? (~acc_lo_r + 32'd1) : acc_lo_r;
        rem_s = neg_r_r ? (~acc_hi_r[XLEN-1:0] + 32'd1) : acc_hi_r[XLEN-1:0];
        case (f3_r)
            F3_MUL:                       fin_res_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_res_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fin_res_s = quo_s;
            F3_REM, F3_REMU:              fin_res_s = rem_s;
            default:                      fin_res_s = 32'd0;
        endcase
    end

    // Accumulator, operand and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            f3_r     <= 3'd0;
            opnd_r   <= 32'd0;
            acc_hi_r <= 33'd0;
            acc_lo_r <= 32'd0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= 32'd0;
        end else if (load) begin
            // Multiply: opnd = multiplicand, lo = multiplier. Divide: opnd = divisor, lo = dividend.
            f3_r     <= funct3;
            opnd_r   <= is_div(funct3) ? b_mag_s : a_mag_s;
            acc_hi_r <= 33'd0;
            acc_lo_r <= is_div(funct3) ? a_mag_s : b_mag_s;
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            result_r <= special_s ? special_res_s : result_r;
        end else if (step) begin
            acc_hi_r <= next_hi_s;
            acc_lo_r <= next_lo_s;
        end else if (finish) begin
            result_r <= fin_res_s;
        end else begin
            result_r <= result_r;
        end
    end

    assign special = special_s;
    assign result  = result_r;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: FSM, iteration counter and registered
// write-back handshake around the shared multiply/divide datapath.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] result
);

    state_e           state_r;
    state_e           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             special_s;
    logic [4:0]       rd_next_s;
    logic             busy_r;
    logic             done_r;
    logic             wb_we_r;
    logic [4:0]       wb_rd_r;

    muldiv_datapath u_datapath (
        .clk     (CLK),
        .reset   (reset),
        .load    (accept_s),
        .step    (state_r == S_CALC),
        .finish  (state_r == S_FINISH),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .special (special_s),
        .result  (result)
    );

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = special_s ? S_DONE : S_CALC;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = S_FINISH;
                end else begin
                    next_state_s = S_CALC;
                end
            end
            S_FINISH: next_state_s = S_DONE;
            S_DONE:   next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
        rd_next_s = accept_s ? rd_in : wb_rd_r;
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wb_we_r <= 1'b0;
            wb_rd_r <= 5'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= (state_r == S_CALC) ? cnt_r + 5'd1 : 5'd0;
            busy_r  <= (next_state_s != S_IDLE);
            done_r  <= (next_state_s == S_DONE);
            wb_we_r <= (next_state_s == S_DONE) && (rd_next_s != 5'd0);
            wb_rd_r <= rd_next_s;
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign wb_we = wb_we_r;
    assign wb_rd = wb_rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors with hand-computed
// results and completion cycles, checked by an independent done monitor.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    muldiv_unit dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .result  (result)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h with no request outstanding (cycle %0d)", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
                chk("wb_we", {31'd0, wb_we}, {31'd0, mon_e.we});
                chk("done_cycle", cyc, mon_e.at);
            end
        end
    end

    // Wait (bounded) for IDLE at a falling edge, pulse start, then scramble operands.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat,
                         input bit expect_done);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, n);
        end
        funct3  = f3;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        if (expect_done) sb.push_back('{exp, rd, (rd != 5'd0), cyc + lat});
        @(negedge CLK);
        start   = 1'b0;
        rs1_val = $urandom;
        rs2_val = $urandom;
        funct3  = 3'($urandom);
        rd_in   = 5'($urandom);
    endtask

    initial begin
        int n;
        int t0;
        reset   = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        rd_in   = 5'd0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_wb_we", {31'd0, wb_we}, 32'd0);
        chk("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge CLK);

        // Full-latency multiply with busy window measured directly.
        issue(F3_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 34, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("busy_cycles_normal", n, 32'd34);

        issue(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 34, 1'b1);
        issue(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd7, 32'hFFFF_FFFF, 34, 1'b1);
        issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 34, 1'b1);
        issue(F3_MUL,    32'hFFFF_FFFD, 32'd5,         5'd9, 32'hFFFF_FFF1, 34, 1'b1);
        issue(F3_MULH,   32'hFFFF_FFFD, 32'd5,         5'd9, 32'hFFFF_FFFF, 34, 1'b1);
        issue(F3_MUL,    32'd0,         32'd12345,     5'd3, 32'd0,         34, 1'b1);
        issue(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, 34, 1'b1);
        issue(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, 34, 1'b1);
        issue(F3_DIV,    32'd7,         32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 34, 1'b1);
        issue(F3_REM,    32'd7,         32'hFFFF_FFFE, 5'd14, 32'd1,         34, 1'b1);
        issue(F3_DIVU,   32'd100,       32'd7,         5'd15, 32'd14,        34, 1'b1);
        issue(F3_REMU,   32'd100,       32'd7,         5'd16, 32'd2,         34, 1'b1);

        // Special cases complete one cycle after start.
        issue(F3_DIV, 32'd5, 32'd0, 5'd17, 32'hFFFF_FFFF, 1, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("busy_cycles_special", n, 32'd1);
        issue(F3_REMU, 32'd5,         32'd0,         5'd18, 32'd5,         1, 1'b1);
        issue(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1, 1'b1);
        issue(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1, 1'b1);

        // start pulsed mid-calculation (a special-case divide) must be ignored.
        issue(F3_MUL, 32'd11, 32'd13, 5'd21, 32'd143, 34, 1'b1);
        repeat (5) @(negedge CLK);
        funct3  = F3_DIVU;
        rs1_val = 32'd9;
        rs2_val = 32'd0;
        rd_in   = 5'd22;
        start   = 1'b1;
        @(negedge CLK);
        start   = 1'b0;

        // rd = 0: result still produced, no register write.
        issue(F3_MUL, 32'd2, 32'd3, 5'd0, 32'd6, 34, 1'b1);

        // Back-to-back: second start lands in the IDLE cycle after DONE.
        issue(F3_DIVU, 32'd1000, 32'd9, 5'd23, 32'd111, 34, 1'b1);
        issue(F3_REMU, 32'd1000, 32'd9, 5'd24, 32'd1,   34, 1'b1);

        // Reset at T+10 of a divide aborts it.
        issue(F3_DIV, 32'd1000, 32'd7, 5'd4, 32'd142, 34, 1'b0);
        t0 = cyc - 1;
        n  = 0;
        while (cyc != t0 + 10 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_wb_we", {31'd0, wb_we}, 32'd0);
        issue(F3_MUL, 32'd3, 32'd3, 5'd1, 32'd9, 34, 1'b1);

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("scoreboard_drain", sb.size(), 32'd0);
        repeat (40) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
